rx_frame_timer: RTL and testbench

Parametrised successor to the UART RX edge/bit counter. It generates per-bit oversampling timing for a complete configurable UART frame (start + 5..8 data + optional parity + 1/2 stop) and then stops, rather than wrapping forever. It also produces three mid-bit sample strobes for majority voting, bit/frame completion pulses and a prescale-legality error. It sits between the RX FSM (which drives enable) and the sampler, parity and stop checkers.

---
 rtl/rx_frame_timer.sv | 141 ++++++++++++++
 tb/tb_rx_frame_timer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/rx_frame_timer.sv
// Oversampling frame timer for the UART receiver. It counts clocks per bit and bits per frame
// for one configurable frame, then parks in DONE until enable drops.
module rx_frame_timer #(
  parameter int PRESC_W = 6,
  parameter int BIT_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [3:0]         data_len,
  input  logic               parity_en,
  input  logic               stop2,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]   bit_cnt,
  output logic               sample_stb,
  output logic [1:0]         sample_idx,
  output logic               bit_done,
  output logic               frame_done,
  output logic               busy,
  output logic               presc_err
);

  typedef enum logic [1:0] {IDLE, COUNT, DONE, ERR} state_t;

  localparam logic [PRESC_W-1:0] P_ONE  = PRESC_W'(1);
  localparam logic [PRESC_W-1:0] P_MIN  = PRESC_W'(4);
  localparam logic [BIT_W-1:0]   B_ONE  = BIT_W'(1);

  state_t             state, state_d;
  logic [PRESC_W-1:0] p_lat, p_d, edge_d;
  logic [BIT_W-1:0]   nb_lat, nb_d, bit_d;
  logic               err_d;
  logic [3:0]         dl_c;
  logic [BIT_W-1:0]   frame_len;
  logic [PRESC_W-1:0] centre, c_lo, c_hi;
  logic               last_edge, last_bit, in_count;

  // Frame length = start + clamped data bits + optional parity + one or two stop bits.
  always_comb begin
    if (data_len < 4'd5)      dl_c = 4'd5;
    else if (data_len > 4'd8) dl_c = 4'd8;
    else                      dl_c = data_len;
  end

  assign frame_len = BIT_W'(dl_c) + BIT_W'(parity_en) + BIT_W'(stop2) + BIT_W'(2);

  assign centre    = p_lat >> 1;
  assign c_lo      = centre - P_ONE;
  assign c_hi      = centre + P_ONE;
  assign in_count  = (state == COUNT);
  assign last_edge = (edge_cnt == p_lat - P_ONE);
  assign last_bit  = (bit_cnt == nb_lat - B_ONE);

  // NOTE: every signal written here gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_d    = state;
    edge_d     = edge_cnt;
    bit_d      = bit_cnt;
    err_d      = presc_err;
    p_d        = p_lat;
    nb_d       = nb_lat;
    sample_stb = 1'b0;
    sample_idx = 2'd0;
    bit_done   = 1'b0;
    frame_done = 1'b0;
    busy       = in_count;

    if (in_count) begin
      sample_stb = (edge_cnt >= c_lo) && (edge_cnt <= c_hi);
      if (sample_stb) sample_idx = 2'(edge_cnt - c_lo);
      bit_done   = last_edge;
      frame_done = last_edge && last_bit;
    end

    // Dropping enable wins over everything, including a coincident frame_done.
    if (!enable) begin
      state_d = IDLE;
      edge_d  = '0;
      bit_d   = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          p_d   = prescale;
          nb_d  = frame_len;
          bit_d = '0;
          if (prescale < P_MIN) begin
            state_d = ERR;
            err_d   = 1'b1;
            edge_d  = '0;
          end else begin
            // The enabling edge itself is edge 0 of the start bit.
            state_d = COUNT;
            edge_d  = P_ONE;
          end
        end
        COUNT: begin
          if (last_edge) begin
            edge_d = '0;
            if (last_bit) begin
              state_d = DONE;
              bit_d   = '0;
            end else begin
              bit_d = bit_cnt + B_ONE;
            end
          end else begin
            edge_d = edge_cnt + P_ONE;
          end
        end
        DONE, ERR: begin
          edge_d = '0;
          bit_d  = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      edge_cnt  <= '0;
      bit_cnt   <= '0;
      presc_err <= 1'b0;
      p_lat     <= '0;
      nb_lat    <= '0;
    end else begin
      state     <= state_d;
      edge_cnt  <= edge_d;
      bit_cnt   <= bit_d;
      presc_err <= err_d;
      p_lat     <= p_d;
      nb_lat    <= nb_d;
    end
  end

endmodule

// File: tb/tb_rx_frame_timer.sv
// Directed bench for rx_frame_timer: whole frames checked cycle by cycle against a
// clock-index model, plus error, abort and async-reset scenarios.
module tb_rx_frame_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [5:0] prescale;
  logic [3:0] data_len;
  logic       parity_en;
  logic       stop2;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       sample_stb;
  logic [1:0] sample_idx;
  logic       bit_done;
  logic       frame_done;
  logic       busy;
  logic       presc_err;

  int n_vec  = 0;
  int n_miss = 0;

  rx_frame_timer #(.PRESC_W(6), .BIT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .prescale   (prescale),
    .data_len   (data_len),
    .parity_en  (parity_en),
    .stop2      (stop2),
    .edge_cnt   (edge_cnt),
    .bit_cnt    (bit_cnt),
    .sample_stb (sample_stb),
    .sample_idx (sample_idx),
    .bit_done   (bit_done),
    .frame_done (frame_done),
    .busy       (busy),
    .presc_err  (presc_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Layout: {presc_err, busy, bit_cnt, edge_cnt, sample_stb, sample_idx, bit_done, frame_done}
  function automatic logic [16:0] pack(input bit err, input bit bsy, input int b, input int e,
                                       input bit stb, input int idx, input bit bd, input bit fd);
    return {err, bsy, 4'(b), 6'(e), stb, 2'(idx), bd, fd};
  endfunction

  function automatic logic [16:0] obs();
    return {presc_err, busy, bit_cnt, edge_cnt, sample_stb, sample_idx, bit_done, frame_done};
  endfunction

  // Global clock index g counts from the enabling edge (g=0); frame occupies g < len.
  task automatic run_frame(input int p, input int dl, input bit par, input bit st2, input int nb,
                           input int len, input int fd_bit, input int fd_edge, input int chg);
    int busy_n, bd_n, fd_n, stb_n, co_n, fb, fe, e, b, c;
    bit bsy, stb, bd, fd;
    busy_n = 0; bd_n = 0; fd_n = 0; stb_n = 0; co_n = 0; fb = -1; fe = -1;
    c = p / 2;
    @(negedge clk);
    prescale = 6'(p); data_len = 4'(dl); parity_en = par; stop2 = st2; enable = 1'b1;
    for (int g = 1; g <= len + 3; g++) begin
      @(negedge clk);
      bsy = (g < len);
      e   = bsy ? g % p : 0;
      b   = bsy ? g / p : 0;
      stb = bsy && (e >= c - 1) && (e <= c + 1);
      bd  = bsy && (e == p - 1);
      fd  = bd && (b == nb - 1);
      check($sformatf("P%0d g%0d", p, g), obs(), pack(0, bsy, b, e, stb, stb ? e - c + 1 : 0, bd, fd));
      busy_n += int'(busy);
      bd_n   += int'(bit_done);
      stb_n  += int'(sample_stb);
      if (frame_done) begin fd_n++; fb = int'(bit_cnt); fe = int'(edge_cnt); end
      if (bit_done && sample_stb && sample_idx == 2'd2) co_n++;
      if (chg != 0 && g == p + 3) prescale = 6'(chg);
    end
    check($sformatf("P%0d frame_clks", p), busy_n + 1, len);
    check($sformatf("P%0d bit_done_n", p), bd_n, nb);
    check($sformatf("P%0d frame_done_n", p), fd_n, 1);
    check($sformatf("P%0d stb_n", p), stb_n, 3 * nb);
    check($sformatf("P%0d fd_bit", p), fb, fd_bit);
    check($sformatf("P%0d fd_edge", p), fe, fd_edge);
    check($sformatf("P%0d bd_idx2_overlap", p), co_n, (p == 4) ? nb : 0);
    enable = 1'b0;
    @(negedge clk);
    check($sformatf("P%0d idle_after", p), obs(), '0);
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; prescale = '0; data_len = '0; parity_en = 1'b0; stop2 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset", obs(), '0);
    rst = 1'b1;

    // 8 data bits, no parity, 1 stop: 10 bits x 8 clocks
    run_frame(8, 8, 0, 0, 10, 80, 9, 7, 0);
    // 5 data + parity + 2 stop = 9 bits x 16; prescale changed mid-frame
    run_frame(16, 5, 1, 1, 9, 144, 8, 15, 8);
    // minimum legal prescale: last strobe lands on bit_done
    run_frame(4, 8, 0, 0, 10, 40, 9, 3, 0);

    // illegal prescale
    @(negedge clk);
    prescale = 6'd3; data_len = 4'd8; enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("err_hold%0d", i), obs(), pack(1, 0, 0, 0, 0, 0, 0, 0));
    end
    enable = 1'b0;
    @(negedge clk);
    check("err_clear", obs(), '0);
    // data_len 2 clamps to 5: 7 bits x 8
    run_frame(8, 2, 0, 0, 7, 56, 6, 7, 0);

    // abort at bit 4 / edge 5
    @(negedge clk);
    prescale = 6'd8; data_len = 4'd8; parity_en = 1'b0; stop2 = 1'b0; enable = 1'b1;
    repeat (37) @(negedge clk);
    check("abort_point", {bit_cnt, edge_cnt}, {4'd4, 6'd5});
    enable = 1'b0;
    @(negedge clk);
    check("abort_clear", obs(), '0);
    run_frame(8, 8, 0, 0, 10, 80, 9, 7, 0);

    // async reset between edges, data_len 12 clamps to 8
    @(negedge clk);
    prescale = 6'd8; data_len = 4'd12; enable = 1'b1;
    repeat (20) @(negedge clk);
    check("pre_rst_busy", busy, 1'b1);
    #2 rst = 1'b0;
    #1 check("async_rst", obs(), '0);
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_frame(8, 12, 0, 0, 10, 80, 9, 7, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
